bfp_add_sub_pipe: RTL and testbench
===================================

Name: bfp_add_sub_pipe

Overview:
- Pipelined block-floating-point adder/subtractor; parametrised successor of the 16-bit combinational scaled add/sub used in the ODE solver datapath.
- Operand word layout: {scale[SCALE_W-1:0], mantissa[MANT_W-1:0]}. Mantissa is signed two's complement. Scale is the count of fractional bits, so value = mantissa / 2^scale.
- Adds over the previous block: valid/ready handshake, a 3-stage pipeline, per-transaction add/sub and carry-in, overflow renormalisation by scale reduction, saturation, and an inexact flag.

Parameters:
- MANT_W, 13, mantissa width in bits (signed).
- SCALE_W, 3, scale field width; MAXS = 2^SCALE_W-1.
- NORM_EN, 1, 1 = renormalise on overflow; 0 = legacy behaviour (wrap low bits and flag invalid).
- Derived W = SCALE_W+MANT_W. Derived IW = MANT_W+MAXS+1, the internal sum width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  input operands are valid.
- in_ready  out  1  block accepts input this cycle.
- in_sub  in  1  1 = a-b, 0 = a+b.
- in_cin  in  1  carry-in, added to the aligned sum (LSB weight).
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  result {scale, mantissa}.
- out_invalid  out  1  result saturated (NORM_EN=1) or wrapped (NORM_EN=0).
- out_inexact  out  1  nonzero bits were discarded by the renormalisation shift.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All stage valid bits are cleared.
  - out_valid=0, out_data=0, out_invalid=0, out_inexact=0.
  - Any in-flight transactions are dropped; no partial result ever appears.
- Pipeline control:
  - adv = !out_valid || out_ready. in_ready = adv.
  - When adv=1 all stages shift by one stage. When adv=0 all stages hold.
  - Bubbles are not compressed.
  - A transfer occurs when in_valid && in_ready.
  - Latency is 3 cycles from the accepting edge to out_valid, assuming no stall.
  - Throughput is 1 result per cycle.
- Output holding: out_data and the flags stay stable while out_valid && !out_ready.
- Stage 1, align:
  - Sign-extend both mantissas to IW.
  - sr = max(sa, sb).
  - Left-shift the operand with the smaller scale by |sa-sb|. This is exact within IW.
  - Register both aligned operands, sr, sub and cin.
- Stage 2, add:
  - s = A + (sub ? ~B : B) + sub + cin, computed at IW+1 bits, signed.
  - sub and cin both set gives a-b+1.
- Stage 3, normalise and pack:
  - If s fits the signed MANT_W range (-2^(MANT_W-1)..2^(MANT_W-1)-1): mantissa = s, scale = sr, both flags 0.
  - Overflow with NORM_EN=1:
    - k = minimum right shift such that (s >>> k) fits; k is found by a priority encoder on the leading sign bits.
    - If k ≤ sr: mantissa = s >>> k (arithmetic shift, truncates toward -inf), scale = sr-k.
    - In that case out_inexact = 1 if any discarded bit is 1.
    - If k > sr: shift by sr, then saturate to max or min by sign of s, scale = 0, out_invalid = 1.
    - out_inexact reflects the discarded bits in the saturating case too.
  - Overflow with NORM_EN=0: mantissa = s[MANT_W-1:0], scale = sr, out_invalid = 1, out_inexact = 0.
  - Result of zero: scale = sr; it is not canonicalised.
- Simultaneous events:
  - Reset has priority over transfer and stall.
  - An input accepted in the same cycle as output drain is legal.

Test Plan:
- Align add, defaults. a=16'h4064 (scale 2, mant 100), b=16'h0003 (scale 0, mant 3), sub=0, cin=0 -> out_data=16'h4070 exactly 3 cycles later, both flags 0.
- Subtract negative. a=16'h200A, b=16'h2019 (scale 1, mant 10 and 25), sub=1 -> out_data=16'h3FF1 (mant -15, scale 1).
- Renormalise. a=b=16'h6FA0 (scale 3, mant 4000), add -> out_data=16'h4FA0 (scale 2, mant 4000), flags 0.
- Inexact. a=16'h2FFF, b=16'h2002 (scale 1, sum 4097) -> out_data=16'h0800, out_inexact=1, out_invalid=0.
- Saturate and legacy mode:
  - a=b=16'h0FFF (scale 0) -> out_data=16'h0FFF, out_invalid=1.
  - Same operands with NORM_EN=0 -> out_data=16'h1FFE, out_invalid=1.
- Backpressure and reset:
  - Stream 5 operand pairs, hold out_ready=0 for 4 cycles. in_ready must drop, out_data must hold, and no result may be lost or duplicated.
  - Assert reset=0 with 2 transactions in flight -> next cycle out_valid=0 and outputs are 0; those 2 results never appear.

Source files
------------

// File: rtl/bfp_add_sub_pipe_if.sv
// Handshake bus for the block-floating-point add/sub pipeline.
// The master drives operands and out_ready; the slave returns results.
interface bfp_add_sub_pipe_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic         in_cin;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_invalid;
  logic         out_inexact;

  modport master (
    output in_valid, in_sub, in_cin, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_invalid, out_inexact
  );

  modport slave (
    input  in_valid, in_sub, in_cin, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_invalid, out_inexact
  );
endinterface

// File: rtl/bfp_add_sub_pipe.sv
// Three-stage block-floating-point adder/subtractor: align, add, normalise/pack.
// Word layout is {scale, signed mantissa}; value = mantissa / 2^scale.
module bfp_add_sub_pipe #(
  parameter int unsigned MANT_W  = 13,
  parameter int unsigned SCALE_W = 3,
  parameter int unsigned NORM_EN = 1
) (
  input logic               clk,
  input logic               reset,
  bfp_add_sub_pipe_if.slave bus
);

  localparam int unsigned MAXS = (1 << SCALE_W) - 1;
  localparam int unsigned W    = SCALE_W + MANT_W;
  localparam int unsigned IW   = MANT_W + MAXS + 1;
  localparam int unsigned KMAX = IW + 1 - MANT_W;
  localparam int unsigned KW   = $clog2(KMAX + 1);
  localparam int unsigned CW   = (KW > SCALE_W) ? KW : SCALE_W;

  localparam logic [MANT_W-1:0] MMAX = {1'b0, {(MANT_W-1){1'b1}}};
  localparam logic [MANT_W-1:0] MMIN = {1'b1, {(MANT_W-1){1'b0}}};

  logic adv;

  // stage 1 state
  logic                     v1;
  logic signed [IW-1:0]     s1_a;
  logic signed [IW-1:0]     s1_b;
  logic [SCALE_W-1:0]       s1_sr;
  logic                     s1_sub;
  logic                     s1_cin;

  // stage 2 state
  logic                     v2;
  logic signed [IW:0]       s2_s;
  logic [SCALE_W-1:0]       s2_sr;

  // output state
  logic                     out_valid_q;
  logic [W-1:0]             out_data_q;
  logic                     out_invalid_q;
  logic                     out_inexact_q;

  // One shared advance keeps all stages in lock-step; bubbles travel with the data.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_invalid = out_invalid_q;
  assign bus.out_inexact = out_inexact_q;

  // Align: shift the operand with the smaller scale up; IW leaves room for MAXS bits.
  logic [SCALE_W-1:0]       sa;
  logic [SCALE_W-1:0]       sb;
  logic signed [MANT_W-1:0] ma;
  logic signed [MANT_W-1:0] mb;
  logic signed [IW-1:0]     ea;
  logic signed [IW-1:0]     eb;
  logic signed [IW-1:0]     al_a;
  logic signed [IW-1:0]     al_b;
  logic [SCALE_W-1:0]       al_sr;

  assign sa = bus.in_a[W-1 -: SCALE_W];
  assign sb = bus.in_b[W-1 -: SCALE_W];
  assign ma = bus.in_a[MANT_W-1:0];
  assign mb = bus.in_b[MANT_W-1:0];
  assign ea = IW'(ma);
  assign eb = IW'(mb);

  always_comb begin
    al_a  = ea;
    al_b  = eb;
    al_sr = sa;
    if (sa >= sb) begin
      al_b = eb << (sa - sb);
    end else begin
      al_a  = ea << (sb - sa);
      al_sr = sb;
    end
  end

  // Add: one extra bit so A +/- B + cin can never wrap.
  logic signed [IW:0] ax;
  logic signed [IW:0] bx;
  logic signed [IW:0] sum_c;

  assign ax    = {s1_a[IW-1], s1_a};
  assign bx    = {s1_b[IW-1], s1_b};
  assign sum_c = ax + (s1_sub ? ~bx : bx) + (IW+1)'(s1_sub) + (IW+1)'(s1_cin);

  // Normalise: k is the smallest right shift that brings s into mantissa range.
  logic signed [IW:0]  tshift;
  logic [CW-1:0]       k_c;
  logic                sat_c;
  logic [CW-1:0]       sh_c;
  logic signed [IW:0]  shifted;
  logic [IW:0]         mask;
  logic [MANT_W-1:0]   mant_c;
  logic [SCALE_W-1:0]  scale_c;
  logic                inv_c;
  logic                inx_c;

  always_comb begin
    tshift = s2_s;
    k_c    = CW'(KMAX);
    for (int k = int'(KMAX); k >= 0; k--) begin
      tshift = s2_s >>> k;
      if ((tshift[IW:MANT_W-1] == '0) || (tshift[IW:MANT_W-1] == '1)) begin
        k_c = CW'(k);
      end
    end

    sat_c   = k_c > CW'(s2_sr);
    sh_c    = sat_c ? CW'(s2_sr) : k_c;
    shifted = s2_s >>> sh_c;
    mask    = ~({(IW+1){1'b1}} << sh_c);

    mant_c  = s2_s[MANT_W-1:0];
    scale_c = s2_sr;
    inv_c   = 1'b0;
    inx_c   = 1'b0;
    if (k_c != '0) begin
      if (NORM_EN != 0) begin
        if (sat_c) begin
          mant_c  = s2_s[IW] ? MMIN : MMAX;
          scale_c = '0;
          inv_c   = 1'b1;
        end else begin
          mant_c  = shifted[MANT_W-1:0];
          scale_c = s2_sr - SCALE_W'(sh_c);
        end
        inx_c = |(s2_s & $signed(mask));
      end else begin
        inv_c = 1'b1;
      end
    end
  end

  // Valid bits and visible outputs; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (adv) begin
      v1          <= bus.in_valid;
      v2          <= v1;
      out_valid_q <= v2;
      if (v2) begin
        out_data_q    <= {scale_c, mant_c};
        out_invalid_q <= inv_c;
        out_inexact_q <= inx_c;
      end
    end
  end

  // Datapath registers are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_a   <= al_a;
      s1_b   <= al_b;
      s1_sr  <= al_sr;
      s1_sub <= bus.in_sub;
      s1_cin <= bus.in_cin;
      s2_s   <= sum_c;
      s2_sr  <= s1_sr;
    end
  end

endmodule

// File: tb/tb_bfp_add_sub_pipe.sv
// Scoreboard bench for bfp_add_sub_pipe: a renormalising instance and a legacy
// (wrap) instance, driven with hand-computed directed vectors.
module tb_bfp_add_sub_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bfp_add_sub_pipe_if #(.W(16)) b0 ();
  bfp_add_sub_pipe_if #(.W(16)) b1 ();

  bfp_add_sub_pipe #(.MANT_W(13), .SCALE_W(3), .NORM_EN(1)) u_norm (
    .clk(clk), .reset(reset), .bus(b0)
  );
  bfp_add_sub_pipe #(.MANT_W(13), .SCALE_W(3), .NORM_EN(0)) u_legacy (
    .clk(clk), .reset(reset), .bus(b1)
  );

  typedef struct {
    logic [15:0] d;
    logic        inv;
    logic        inx;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one operand pair; the expectation is queued at the accepting edge.
  task automatic send(input bit sel, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic cin, input logic [15:0] ed,
                      input logic einv, input logic einx, input bit lat, input bit track);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    if (sel) begin
      b1.in_valid = 1'b1; b1.in_a = a; b1.in_b = b; b1.in_sub = sub; b1.in_cin = cin;
    end else begin
      b0.in_valid = 1'b1; b0.in_a = a; b0.in_b = b; b0.in_sub = sub; b0.in_cin = cin;
    end
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if ((sel ? b1.in_ready : b0.in_ready) == 1'b1) begin
        e.d   = ed;
        e.inv = einv;
        e.inx = einx;
        e.lat = lat ? cyc + 3 : -1;
        if (track) begin
          if (sel) q1.push_back(e);
          else     q0.push_back(e);
        end
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for operand a=%h", a);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel);
    for (int n = 0; n < 100; n++) begin
      if ((sel ? q1.size() : q0.size()) == 0) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: dut%0d still owes %0d results", sel, sel ? q1.size() : q0.size());
  endtask

  // Monitor for the renormalising instance, including output-hold checks.
  logic        hv0 = 1'b0;
  logic [15:0] hd0;
  logic [1:0]  hf0;
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      hv0 = 1'b0;
    end else begin
      if (hv0 && b0.out_valid) begin
        chk("hold_data", b0.out_data, hd0);
        chk("hold_flags", {b0.out_invalid, b0.out_inexact}, hf0);
      end
      hv0 = 1'b0;
      if (b0.out_valid && b0.out_ready) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut0_unexpected_output: got %h, expected no output", b0.out_data);
        end else begin
          e0 = q0.pop_front();
          chk("dut0_data", b0.out_data, e0.d);
          chk("dut0_invalid", b0.out_invalid, e0.inv);
          chk("dut0_inexact", b0.out_inexact, e0.inx);
          if (e0.lat >= 0) chk("dut0_latency", cyc, e0.lat);
        end
      end else if (b0.out_valid) begin
        hv0 = 1'b1;
        hd0 = b0.out_data;
        hf0 = {b0.out_invalid, b0.out_inexact};
      end
    end
  end

  // Monitor for the legacy instance.
  always begin
    @(negedge clk);
    #1;
    if (reset && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_output: got %h, expected no output", b1.out_data);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_data", b1.out_data, e1.d);
        chk("dut1_invalid", b1.out_invalid, e1.inv);
        chk("dut1_inexact", b1.out_inexact, e1.inx);
        if (e1.lat >= 0) chk("dut1_latency", cyc, e1.lat);
      end
    end
  end

  initial begin
    bit got;
    reset = 1'b0;
    b0.in_valid = 1'b0; b0.in_sub = 1'b0; b0.in_cin = 1'b0; b0.in_a = '0; b0.in_b = '0;
    b1.in_valid = 1'b0; b1.in_sub = 1'b0; b1.in_cin = 1'b0; b1.in_a = '0; b1.in_b = '0;
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", b0.out_valid, 1'b0);
    chk("reset_out_data", b0.out_data, 16'h0000);
    chk("reset_flags", {b0.out_invalid, b0.out_inexact}, 2'b00);
    chk("reset_in_ready", b0.in_ready, 1'b1);
    chk("reset_legacy_valid", b1.out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // sel  a         b         sub   cin   expect    inv   inx   lat track
    send(0, 16'h4064, 16'h0003, 1'b0, 1'b0, 16'h4070, 1'b0, 1'b0, 1, 1); // align add
    send(0, 16'h200A, 16'h2019, 1'b1, 1'b0, 16'h3FF1, 1'b0, 1'b0, 1, 1); // 10-25 = -15
    send(0, 16'h6FA0, 16'h6FA0, 1'b0, 1'b0, 16'h4FA0, 1'b0, 1'b0, 1, 1); // renorm exact
    send(0, 16'h2FFF, 16'h2002, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b1, 1, 1); // renorm inexact
    send(0, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1, 1); // saturate max
    send(0, 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1, 1); // carry-in
    send(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1, 1); // a-b+1
    send(0, 16'h6005, 16'h6005, 1'b1, 1'b0, 16'h6000, 1'b0, 1'b0, 1, 1); // zero keeps scale
    send(0, 16'h1000, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1, 1); // saturate min
    send(0, 16'h2FFF, 16'h0FFF, 1'b0, 1'b0, 16'h0FFF, 1'b1, 1'b1, 1, 1); // saturate, bits lost
    send(0, 16'h7000, 16'h7FFF, 1'b0, 1'b0, 16'h57FF, 1'b0, 1'b1, 1, 1); // negative renorm
    send(0, 16'hE001, 16'h0001, 1'b0, 1'b0, 16'hE081, 1'b0, 1'b0, 1, 1); // max scale gap
    idle();
    wait_drain(0);

    // Backpressure: five pairs while the sink stalls for four cycles.
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(0, 16'(i * 10), 16'(i), 1'b0, 1'b0, 16'(i * 11), 1'b0, 1'b0, 0, 1);
        idle();
      end
      begin
        @(negedge clk);
        b0.out_ready = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
          @(negedge clk);
          #1;
          if (b0.out_valid) got = 1'b1;
        end
        if (!got) begin
          checks++;
          failures++;
          $display("FAIL stall_no_output: out_valid never rose");
        end
        for (int i = 0; i < 4; i++) begin
          if (i > 0) begin
            @(negedge clk);
            #1;
          end
          chk("stall_in_ready", b0.in_ready, 1'b0);
        end
        @(negedge clk);
        b0.out_ready = 1'b1;
      end
    join
    wait_drain(0);
    repeat (3) @(negedge clk);

    // Reset with two transactions in flight: they must never surface.
    send(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 0, 0);
    send(0, 16'h0004, 16'h0005, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    b0.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("inflight_reset_valid", b0.out_valid, 1'b0);
    chk("inflight_reset_data", b0.out_data, 16'h0000);
    chk("inflight_reset_flags", {b0.out_invalid, b0.out_inexact}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // Legacy instance: overflow wraps low bits and flags invalid.
    send(1, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 16'h1FFE, 1'b1, 1'b0, 1, 1);
    send(1, 16'h6FA0, 16'h6FA0, 1'b0, 1'b0, 16'h7F40, 1'b1, 1'b0, 1, 1);
    send(1, 16'h4064, 16'h0003, 1'b0, 1'b0, 16'h4070, 1'b0, 1'b0, 1, 1);
    idle();
    wait_drain(1);
    repeat (3) @(negedge clk);

    chk("dut0_queue_empty", q0.size(), 0);
    chk("dut1_queue_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
